// File: rtl/run_launcher.sv
// run_launcher: host-side initiator that loads operands, launches the core,
// waits for done with a timeout, then drains result words to the host.
module run_launcher #(
  parameter int         N_IN     = 8,
  parameter int         N_OUT    = 4,
  parameter logic [7:0] OUT_BASE = 8'd64,
  parameter int         TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_reset,
  output logic        req,
  input  logic        done,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        fin,
  output logic        timeout_err,
  output logic [15:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CPU_RST, S_REQ,
    S_RUN, S_DRAIN, S_FINISH
  } state_t;

  state_t      r_state;
  logic [8:0]  r_idx;
  logic [31:0] r_cnt;
  logic        r_to;
  logic [15:0] r_cyc;

  logic [31:0] w_k;
  logic [15:0] w_k_sat;
  logic        w_last_in;
  logic        w_last_out;
  logic        w_tmo;

  // r_cnt holds completed RUN cycles, so the current cycle number is r_cnt+1
  assign w_k        = r_cnt + 32'd1;
  assign w_k_sat    = (w_k > 32'h0000_FFFF) ? 16'hFFFF : w_k[15:0];
  assign w_last_in  = (r_idx == 9'(N_IN - 1));
  assign w_last_out = (r_idx == 9'(N_OUT - 1));
  assign w_tmo      = (r_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
      r_cyc   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_to    <= 1'b0;
            r_cyc   <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_idx <= r_idx + 9'd1;
            if (w_last_in) r_state <= S_CPU_RST;
          end
        end
        S_CPU_RST: begin
          r_state <= S_REQ;
          r_cnt   <= '0;
        end
        S_REQ: r_state <= S_RUN;
        S_RUN: begin
          if (done) begin
            r_cyc   <= w_k_sat;
            r_idx   <= '0;
            r_state <= S_DRAIN;
          end else if (w_tmo) begin
            r_to    <= 1'b1;
            r_cyc   <= w_k_sat;
            r_state <= S_FINISH;
          end else begin
            r_cnt <= w_k;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_idx <= r_idx + 9'd1;
            if (w_last_out) r_state <= S_FINISH;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_reset = 1'b1;
    req       = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    fin       = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        in_ready  = 1'b1;
        mem_we    = in_valid;
        mem_addr  = r_idx[7:0];
        mem_wdata = in_data;
      end
      S_REQ: begin
        cpu_reset = 1'b0;
        req       = 1'b1;
      end
      S_RUN: cpu_reset = 1'b0;
      S_DRAIN: begin
        cpu_reset = 1'b0;
        mem_addr  = OUT_BASE + r_idx[7:0];
        out_valid = 1'b1;
        out_data  = mem_rdata;
      end
      S_FINISH: fin = 1'b1;
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_to;
  assign run_cycles  = r_cyc;

endmodule

// File: doc/run_launcher.md
# run_launcher

Host-side initiator for the processor's `req`/`done` run interface. It streams input operands into data memory through a write port, holds the core in reset, pulses `req` to launch the program, and waits for `done` with a timeout. It then reads result words back from data memory and streams them out. It sits between the external host (testbench or harness) and the `top_level` core plus its data-memory port.

## Interface
- `N_IN`, 8: words loaded into data memory, addresses 0..N_IN-1 (1..256)
- `N_OUT`, 4: result words read back (1..256)
- `OUT_BASE`, 8'd64: first result address
- `TIMEOUT`, 4096: maximum RUN cycles before abort (≥2)
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-low
- `start` input 1: begin a run; sampled only in IDLE
- `in_valid` input 1: input word available
- `in_data` input 8: input word
- `in_ready` output 1: launcher accepts `in_data` this cycle
- `mem_we` output 1: data-memory write enable
- `mem_addr` output 8: data-memory address (write and read)
- `mem_wdata` output 8: data-memory write data
- `mem_rdata` input 8: data-memory read data, combinational from `mem_addr`
- `cpu_reset` output 1: active-high reset to core
- `req` output 1: run request to core
- `done` input 1: core finished, level
- `out_valid` output 1: result word available
- `out_data` output 8: result word
- `out_ready` input 1: host accepts result
- `busy` output 1: not in IDLE
- `fin` output 1: one-cycle pulse at end of run
- `timeout_err` output 1: sticky; last run aborted on timeout
- `run_cycles` output 16: RUN-state cycle count of the last run, saturating at 16'hFFFF

## Operation
- States: IDLE, LOAD, CPU_RST, REQ, RUN, DRAIN, FINISH.
- **IDLE**: `cpu_reset`=1. On `start`=1, go to LOAD, clear `idx`, clear `timeout_err`, and clear `run_cycles`.
- **LOAD**:
  - `in_ready`=1 and `cpu_reset`=1.
  - `mem_we`=`in_valid`, `mem_addr`=`idx`, and `mem_wdata`=`in_data`, all combinational.
  - Each accepted word increments `idx`.
  - The N_IN-th accept goes to CPU_RST.
- **CPU_RST**: one cycle, `cpu_reset`=1, then REQ.
- **REQ**: one cycle, `cpu_reset`=0, `req`=1, then RUN.
- **RUN**:
  - `cpu_reset`=0 and `req`=0.
  - The cycle counter increments every cycle.
  - `done`=1 latches `run_cycles`, clears `idx`, and goes to DRAIN.
  - If the counter reaches TIMEOUT-1 with `done`=0, set `timeout_err`, latch `run_cycles`, and go to FINISH, skipping DRAIN.
  - `done` and timeout in the same cycle: `done` wins and no error is flagged.
- **DRAIN**:
  - `cpu_reset`=0, so the core holds its state and memory.
  - `mem_addr`=OUT_BASE+`idx` (mod 256), `out_valid`=1, and `out_data`=`mem_rdata`.
  - On `out_ready`, increment `idx`.
  - The N_OUT-th transfer goes to FINISH.
- **FINISH**: `fin`=1 for one cycle, `cpu_reset`=1, then IDLE.
- `start` outside IDLE is ignored.
- `in_valid` outside LOAD is ignored, with `in_ready`=0.
- `done` outside RUN is ignored.

## Timing
- **Reset (`reset`=0, async)**:
  - State goes to IDLE and `idx`=0.
  - `cpu_reset`=1.
  - `req`, `in_ready`, `mem_we`, `out_valid`, `busy`, `fin`, and `timeout_err` are 0.
  - `mem_addr`, `mem_wdata`, `out_data` (driven 0 when not valid), and `run_cycles` are 0.
- Reset mid-run aborts immediately; no `fin`.
- `start` high at edge t puts LOAD in effect from t+1. `busy` is registered from the state, so it is high from t+1.
- The LOAD handshake is single-cycle per word with no wait states; back-to-back accepts are allowed.
- `req` is exactly one cycle wide, exactly 2 cycles after the final LOAD accept.
- RUN counting:
  - The first RUN cycle counts as 1.
  - `done` sampled high in the k-th RUN cycle gives `run_cycles`=k.
  - A timeout gives `run_cycles`=TIMEOUT.
- DRAIN: `out_data` is valid in the same cycle as `out_valid`. `out_data` is held while `out_valid`=1 and `out_ready`=0.
- Minimum run latency (start to `fin`) is N_IN + 2 + k + N_OUT + 2 cycles, assuming in/out are always valid/ready.
- Counter width: `idx` is 9 bits so that a count of 256 is representable.

## Test plan
- **Nominal run**: N_IN=8, N_OUT=4, data 1..8, `done` asserted on the 20th RUN cycle, `out_ready`=1.
  - Writes to addresses 0..7.
  - `req` pulses once.
  - `run_cycles`=20.
  - Four outputs from addresses 64..67.
  - `fin` pulses once.
  - `timeout_err`=0.
- **Input backpressure**: `in_valid` toggles 1,0,1,0.
  - Exactly 8 writes occur with consecutive addresses.
  - The CPU_RST→REQ spacing is unchanged.
- **Output backpressure**: `out_ready` low for 3 cycles on word 2.
  - `out_data` is held stable.
  - No address skip.
  - 4 words total.
- **Timeout**: TIMEOUT=16, `done` never asserted.
  - `timeout_err`=1 and `run_cycles`=16.
  - No `out_valid`.
  - `fin` pulses.
  - The next `start` clears `timeout_err`.
- **Done on the timeout cycle**: `done`=1 exactly on RUN cycle 16 with TIMEOUT=16.
  - DRAIN is entered.
  - `timeout_err`=0.
- **Async reset mid-RUN and mid-DRAIN**:
  - All outputs take their reset values within the same cycle, with `cpu_reset`=1.
  - No `fin`.
  - After release, `start` works normally.
